sad_window_buffer: RTL and testbench

Parametrised single-line pixel buffer for the SAD disparity engine. It accepts P pixels per beat from the pixel stream and presents a sliding window of WIN = MAX_DISP+KERNEL pixels to the SAD array, advancing P pixels per consumed beat. Unlike the previous line buffer, it has full valid/ready flow control on both sides and occupancy tracking. Writes of line n+1 can overlap reads of line n. Window pixels beyond the line end are padded.

---
 rtl/sad_window_buffer.sv | 63 ++++++
 tb/tb_sad_window_buffer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sad_window_buffer.sv
// sad_window_buffer: single-line pixel buffer presenting a padded sliding window with valid/ready on both sides
module sad_window_buffer #(
    parameter int WIDTH = 740,
    parameter int PIX_PER_BEAT = 4,
    parameter int MAX_DISP = 64,
    parameter int KERNEL = 3,
    parameter logic [7:0] PAD = 8'h00,
    localparam int WIN = MAX_DISP + KERNEL,
    localparam int PTR_W = $clog2(WIDTH),
    localparam int FILL_W = $clog2(WIDTH + 1),
    localparam int CNT_W = $clog2(WIN + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_clear,
    input  logic [8*PIX_PER_BEAT-1:0] i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [8*WIN-1:0]        o_data,
    output logic [CNT_W-1:0]        o_valid_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_sol,
    output logic                    o_eol,
    output logic [FILL_W-1:0]       o_fill
);
    localparam int P = PIX_PER_BEAT;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(WIDTH - P);
    logic [7:0] mem [WIDTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [FILL_W-1:0] fill;
    logic wfire, rfire;
    assign o_ready = fill <= FILL_W'(WIDTH - P);
    assign o_valid_data = (int'(rd_ptr) + WIN <= WIDTH) ? CNT_W'(WIN) : CNT_W'(WIDTH - int'(rd_ptr));
    assign o_valid = int'(fill) >= int'(o_valid_data);
    assign o_sol = rd_ptr == '0;
    assign o_eol = rd_ptr == LAST;
    assign o_fill = fill;
    assign wfire = i_valid && o_ready;
    assign rfire = o_valid && i_ready;
    // window never wraps into the next line: slots past the line end read as PAD
    for (genvar i = 0; i < WIN; i++) begin : g_win
        assign o_data[8*i+:8] = (int'(rd_ptr) + i < WIDTH) ? mem[rd_ptr + PTR_W'(i)] : PAD;
    end
    always_ff @(posedge clk) begin
        if (wfire)
            for (int k = 0; k < P; k++)
                mem[wr_ptr + PTR_W'(k)] <= i_data[8*k+:8];
    end
    always_ff @(posedge clk) begin
        if (!rstn || i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill <= '0;
        end else begin
            if (wfire)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(P);
            if (rfire)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(P);
            fill <= fill + (wfire ? FILL_W'(P) : '0) - (rfire ? FILL_W'(P) : '0);
        end
    end
endmodule

// File: tb/tb_sad_window_buffer.sv
// tb_sad_window_buffer: directed checks of fill, backpressure, line-end padding, overlap and clear
module tb_sad_window_buffer;
  localparam int W = 740;
  localparam int P = 4;
  localparam int WIN = 67;
  logic clk = 0;
  logic rstn = 0;
  logic i_clear = 0;
  logic [8*P-1:0] i_data = '0;
  logic i_valid = 0;
  logic i_ready = 0;
  logic o_ready, o_valid, o_sol, o_eol;
  logic [8*WIN-1:0] o_data;
  logic [6:0] o_valid_data;
  logic [9:0] o_fill;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_mem [W];
  int m_fill = 0, m_rd = 0, m_wr = 0, m_s = 0;
  sad_window_buffer #(.WIDTH(W), .PIX_PER_BEAT(P), .MAX_DISP(64), .KERNEL(3), .PAD(8'h00)) dut (
    .clk(clk), .rstn(rstn), .i_clear(i_clear), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid_data(o_valid_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_sol(o_sol), .o_eol(o_eol), .o_fill(o_fill)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    n_fail++;
    $error("FAIL timeout: simulation did not finish in time");
    $finish;
  end
  task automatic chk(input string tag, input logic [8*WIN-1:0] obs, input logic [8*WIN-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] pix(input int s);
    return 8'(s * 37 + 11);
  endfunction
  function automatic int vd(input int rd);
    return (rd + WIN <= W) ? WIN : W - rd;
  endfunction
  task automatic cyc(input bit v, input bit r, input bit c = 0);
    bit wf, rf;
    logic [8*WIN-1:0] ew;
    wf = v && !c && m_fill <= W - P;
    rf = r && !c && m_fill >= vd(m_rd);
    i_valid = v;
    i_ready = r;
    i_clear = c;
    for (int k = 0; k < P; k++) i_data[8*k+:8] = pix(m_s + k);
    @(posedge clk);
    #1;
    if (c) begin
      m_fill = 0; m_rd = 0; m_wr = 0;
    end else begin
      if (wf) begin
        for (int k = 0; k < P; k++) exp_mem[m_wr + k] = pix(m_s + k);
        m_wr = (m_wr == W - P) ? 0 : m_wr + P;
        m_s += P;
        m_fill += P;
      end
      if (rf) begin
        m_rd = (m_rd == W - P) ? 0 : m_rd + P;
        m_fill -= P;
      end
    end
    chk("fill", int'(o_fill), m_fill);
    chk("ready", o_ready, 1'(m_fill <= W - P));
    chk("valid", o_valid, 1'(m_fill >= vd(m_rd)));
    chk("valid_data", int'(o_valid_data), vd(m_rd));
    chk("sol", o_sol, 1'(m_rd == 0));
    chk("eol", o_eol, 1'(m_rd == W - P));
    if (m_fill >= vd(m_rd)) begin
      for (int i = 0; i < WIN; i++) ew[8*i+:8] = (m_rd + i < W) ? exp_mem[m_rd + i] : 8'h00;
      chk("window", o_data, ew);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_fill", o_fill, 10'd0);
    chk("rst_sol", o_sol, 1'b1);
    chk("rst_eol", o_eol, 1'b0);
    chk("rst_vd", o_valid_data, 7'd67);
    rstn = 1;
    repeat (16) cyc(1, 0);
    chk("fill64", o_fill, 10'd64);
    chk("not_valid64", o_valid, 1'b0);
    cyc(1, 0);
    chk("valid68", o_valid, 1'b1);
    chk("fill68", o_fill, 10'd68);
    chk("byte0", o_data[7:0], pix(0));
    chk("byte66", o_data[66*8+:8], pix(66));
    repeat (168) cyc(1, 0);
    chk("full_fill", o_fill, 10'd740);
    chk("full_ready", o_ready, 1'b0);
    cyc(1, 0);
    chk("held_fill", o_fill, 10'd740);
    cyc(1, 1);
    chk("read_fill", o_fill, 10'd736);
    chk("read_ready", o_ready, 1'b1);
    chk("read_byte0", o_data[7:0], pix(4));
    cyc(1, 0);
    chk("held_written", o_fill, 10'd740);
    repeat (168) cyc(0, 1);
    chk("clamp_vd", o_valid_data, 7'd64);
    chk("clamp_last", o_data[63*8+:8], pix(739));
    chk("pad64", o_data[64*8+:8], 8'h00);
    chk("pad66", o_data[66*8+:8], 8'h00);
    repeat (15) cyc(0, 1);
    chk("end_vd", o_valid_data, 7'd4);
    chk("end_eol", o_eol, 1'b1);
    chk("end_byte3", o_data[3*8+:8], pix(739));
    cyc(0, 1);
    chk("wrap_sol", o_sol, 1'b1);
    chk("wrap_fill", o_fill, 10'd4);
    chk("wrap_valid", o_valid, 1'b0);
    repeat (184) cyc(1, 0);
    chk("line1_full", o_fill, 10'd740);
    repeat (185) cyc(1, 1);
    chk("overlap_fill", o_fill, 10'd736);
    chk("overlap_sol", o_sol, 1'b1);
    chk("line2_byte0", o_data[7:0], pix(1480));
    repeat (5) cyc(0, 1);
    cyc(0, 0, 1);
    chk("clr_fill", o_fill, 10'd0);
    chk("clr_sol", o_sol, 1'b1);
    chk("clr_valid", o_valid, 1'b0);
    repeat (125) cyc(1, 0);
    repeat (75) cyc(0, 1);
    chk("mid_fill", o_fill, 10'd200);
    chk("mid_byte0", o_data[7:0], pix(2516));
    cyc(0, 1, 1);
    chk("mid_clr_fill", o_fill, 10'd0);
    chk("mid_clr_sol", o_sol, 1'b1);
    chk("mid_clr_valid", o_valid, 1'b0);
    chk("mid_clr_ready", o_ready, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
